fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_pkg.sv | 29 ++
 rtl/fifo_rd_oreg.sv | 45 ++++
 rtl/fifo_rd_ctrl.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_rd_pkg                                              |
// | Description : Shared definitions for the FIFO burst read controller:   |
// |               FSM state encoding, pop-counter width and the pop-counter |
// |               saturating increment helper.                             |
// | Ports       : none (package)                                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package fifo_rd_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_t;

  // Width of the optional total-pop counter.
  localparam int RD_COUNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RD_COUNT_W-1:0] sat_inc(input logic [RD_COUNT_W-1:0] v);
    return (&v) ? v : v + RD_COUNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_oreg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_rd_oreg                                             |
// | Description : Single-entry downstream output register. Captures a      |
// |               popped FIFO word, holds it until the consumer accepts    |
// |               it, and frees itself on acceptance unless a new word is  |
// |               loaded on the same edge.                                 |
// | Ports       : clk    - clock (rising edge)                             |
// |               rst_n  - asynchronous active-low reset                   |
// |               load   - capture din this edge (FIFO pop strobe)         |
// |               din    - word to capture                                 |
// |               ready  - downstream ready                                |
// |               data   - registered downstream data                      |
// |               valid  - downstream valid                                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fifo_rd_oreg #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] din,
  input  logic             ready,
  output logic [DSIZE-1:0] data,
  output logic             valid
);

  // A load always wins: on a simultaneous accept and pop the slot is
  // refilled, so valid stays high and the new word replaces the old one.
  // With valid=1 and ready=0 nothing changes, which keeps the word stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_rd_ctrl                                             |
// | Description : Burst read controller for the read side of a FIFO.       |
// |               A start request pops burst_len words, pushing each one   |
// |               through a one-entry output register to a valid/ready     |
// |               consumer, then pulses done for one cycle.                |
// | Ports       : rclk       - clock (rising edge)                         |
// |               rrst_n     - asynchronous active-low reset               |
// |               start      - burst request, honoured only when idle      |
// |               burst_len  - words to pop, captured with start           |
// |               rempty     - FIFO empty flag                             |
// |               rdata      - FIFO head word (valid while rempty=0)       |
// |               rinc       - FIFO pop strobe (combinational)             |
// |               out_data   - registered downstream data                  |
// |               out_valid  - downstream valid                            |
// |               out_ready  - downstream ready                            |
// |               busy       - controller not idle                         |
// |               done       - one-cycle burst completion pulse            |
// |               rd_count   - total pops since reset, saturating          |
// |                            (only with FIFO_RD_CTRL_CNT_EN defined)     |
// | Build macro : FIFO_RD_CTRL_CNT_EN - adds the rd_count output/counter   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int BLEN_W = 5
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  start,
  input  logic [BLEN_W-1:0]     burst_len,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  output logic [DSIZE-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [RD_COUNT_W-1:0] rd_count
`endif
);

  rd_state_t         state;
  logic [BLEN_W-1:0] remaining;
  logic              busy_q;
  logic              done_q;

  // Pop only when there is a word, words are still owed, and the output
  // slot is either free or being emptied on this same edge.
  assign rinc = (state == READ) && !rempty && (remaining != '0) &&
                (!out_valid || out_ready);

  assign busy = busy_q;
  assign done = done_q;

  // ---------------------------------------------------------------------
  // Burst sequencing. busy and done are registered alongside the state so
  // that they are glitch-free: busy mirrors state != IDLE, done is high
  // exactly during the single FIN cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (burst_len != '0) begin
              remaining <= burst_len;
              state     <= READ;
            end else begin
              // Empty burst: nothing to pop, complete straight away.
              state  <= FIN;
              done_q <= 1'b1;
            end
          end
        end

        READ: begin
          // rinc already guarantees remaining != 0, so this cannot wrap.
          // An empty FIFO simply stalls here for as long as it stays empty.
          if (rinc) begin
            remaining <= remaining - BLEN_W'(1);
            if (remaining == BLEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // No pops happen here, so an accept always empties the slot.
          if (!out_valid || out_ready) begin
            state  <= FIN;
            done_q <= 1'b1;
          end
        end

        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Downstream output register.
  fifo_rd_oreg #(
    .DSIZE (DSIZE)
  ) u_oreg (
    .clk   (rclk),
    .rst_n (rrst_n),
    .load  (rinc),
    .din   (rdata),
    .ready (out_ready),
    .data  (out_data),
    .valid (out_valid)
  );

`ifdef FIFO_RD_CTRL_CNT_EN
  // Lifetime pop counter; holds at all-ones once it gets there.
  logic [RD_COUNT_W-1:0] pop_count;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_count <= '0;
    end else if (rinc) begin
      pop_count <= sat_inc(pop_count);
    end
  end

  assign rd_count = pop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_fifo_rd_ctrl                                          |
// | Description : Self-checking bench for fifo_rd_ctrl. The bench owns the |
// |               FIFO (a queue), a reference list of written words and a  |
// |               downstream sink, and checks every burst's delivered word |
// |               stream, pop count, done timing and FIFO level.           |
// | Build macro : FIFO_RD_CTRL_CNT_EN - also exercises rd_count            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_fifo_rd_ctrl;

  localparam int DSIZE  = 8;
  localparam int BLEN_W = 5;

  logic              rclk      = 1'b0;
  logic              rrst_n    = 1'b0;
  logic              start     = 1'b0;
  logic [BLEN_W-1:0] burst_len = '0;
  logic              rempty    = 1'b1;
  logic [DSIZE-1:0]  rdata     = '0;
  logic              rinc;
  logic [DSIZE-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0]       rd_count;
`endif

  fifo_rd_ctrl #(
    .DSIZE  (DSIZE),
    .BLEN_W (BLEN_W)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .start     (start),
    .burst_len (burst_len),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  // Bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pops = 0;
  int done_cnt = 0;
  int last_pop_cyc = 0;
  int last_done_cyc = 0;
  int ready_pct = 100;
  int wr_pct = 0;

  logic [DSIZE-1:0] fifo_q[$];   // FIFO contents as the DUT sees them
  logic [DSIZE-1:0] ref_q[$];    // words written and not yet owed to a burst
  logic [DSIZE-1:0] acc_q[$];    // words accepted downstream
  int               acc_cyc_q[$];

  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;
  logic             prev_done = 1'b0;
  logic [DSIZE-1:0] prev_d = '0;

  int b_d0, b_a0, b_p0, b_len, b_start_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic fifo_refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
    fifo_refresh();
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    ref_q.delete();
    fifo_refresh();
  endtask

  // One clock: sample at the falling edge (these values act on the next
  // rising edge), then update FIFO/stimulus 1 time unit after the rising edge.
  task automatic tick();
    logic [DSIZE-1:0] w;
    bit               do_pop;
    @(negedge rclk);
    do_pop = (rinc === 1'b1);
    if (rrst_n) begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_d));
      end
      if (do_pop) begin
        check("pop_nonempty", 32'(rempty), 32'd0);
        pops++;
        last_pop_cyc = cyc;
      end
      if (done === 1'b1) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        acc_q.push_back(out_data);
        acc_cyc_q.push_back(cyc);
      end
    end
    prev_v    = out_valid;
    prev_r    = out_ready;
    prev_d    = out_data;
    prev_done = done;
    @(posedge rclk);
    cyc++;
    #1;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
    if (wr_pct > 0 && $urandom_range(0, 99) < wr_pct) begin
      w = DSIZE'($urandom);
      push_word(w);
    end
    out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic burst_start(input int len);
    b_d0        = done_cnt;
    b_a0        = acc_q.size();
    b_p0        = pops;
    b_len       = len;
    b_start_cyc = cyc;
    start       = 1'b1;
    burst_len   = len[BLEN_W-1:0];
    tick();
    start       = 1'b0;
  endtask

  // Waits for completion and checks the burst against the reference:
  // exactly len pops, the next len written words delivered in order,
  // one done pulse, back to idle, FIFO level consistent.
  task automatic burst_finish(input int budget);
    int               k = 0;
    logic [DSIZE-1:0] exp_w;
    logic [DSIZE-1:0] act_w;
    while (done_cnt == b_d0 && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt - b_d0), 32'd1);
    tick();
    check("done_single", 32'(done_cnt - b_d0), 32'd1);
    check("idle_after", 32'(busy), 32'd0);
    check("burst_pops", 32'(pops - b_p0), 32'(b_len));
    check("burst_accepts", 32'(acc_q.size() - b_a0), 32'(b_len));
    for (int i = 0; i < b_len; i++) begin
      exp_w = (ref_q.size() > 0) ? ref_q.pop_front() : '1;
      act_w = (b_a0 + i < acc_q.size()) ? acc_q[b_a0 + i] : ~exp_w;
      check("burst_data", 32'(act_w), 32'(exp_w));
    end
    check("fifo_level", 32'(fifo_q.size()), 32'(ref_q.size()));
  endtask

  task automatic do_burst(input int len);
    burst_start(len);
    burst_finish(3000);
  endtask

  initial begin
    int stall_pops;
    logic [DSIZE-1:0] held;
    int len;
    int pre;
    int k;

    fifo_refresh();

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    rrst_n = 1'b1;
    tick();

    // Preloaded 0..15, burst of 4 at full rate
    for (int i = 0; i < 16; i++) push_word(DSIZE'(i));
    ready_pct = 100;
    out_ready = 1'b1;
    burst_start(4);
    burst_finish(100);
    check("t1_consecutive", 32'(acc_cyc_q[b_a0 + 3] - acc_cyc_q[b_a0]), 32'd3);
    check("t1_done_latency", 32'(last_done_cyc - last_pop_cyc), 32'd2);
    check("t1_left", 32'(fifo_q.size()), 32'd12);

    // Burst of 8 with only 3 words present; rest arrives 20 cycles later
    clear_fifo();
    for (int i = 0; i < 3; i++) push_word(DSIZE'(8'hA0 + i));
    burst_start(8);
    repeat (19) tick();
    check("t2_gap_pops", 32'(pops - b_p0), 32'd3);
    check("t2_gap_busy", 32'(busy), 32'd1);
    check("t2_gap_nodone", 32'(done_cnt - b_d0), 32'd0);
    check("t2_gap_rinc", 32'(rinc), 32'd0);
    for (int i = 3; i < 8; i++) push_word(DSIZE'(8'hA0 + i));
    burst_finish(100);
    check("t2_empty", 32'(fifo_q.size()), 32'd0);

    // Downstream stall of 5 cycles mid-burst
    clear_fifo();
    for (int i = 0; i < 10; i++) push_word(DSIZE'(8'h40 + i));
    burst_start(8);
    repeat (2) tick();
    ready_pct = 0;
    tick();
    stall_pops = pops;
    held = out_data;
    repeat (4) tick();
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    check("t3_stall_data", 32'(out_data), 32'(held));
    ready_pct = 100;
    tick();
    check("t3_stall_nopop", 32'(pops - stall_pops), 32'd0);
    burst_finish(100);
    check("t3_left", 32'(fifo_q.size()), 32'd2);

    // Zero-length burst
    k = pops;
    burst_start(0);
    burst_finish(10);
    check("t4_done_latency", 32'(last_done_cyc - b_start_cyc), 32'd1);
    check("t4_no_pop", 32'(pops - k), 32'd0);

    // Reset after 2 of 6 pops
    clear_fifo();
    for (int i = 0; i < 6; i++) push_word(DSIZE'(8'hC0 + i));
    burst_start(6);
    k = 0;
    while (pops - b_p0 < 2 && k < 20) begin
      tick();
      k++;
    end
    rrst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rinc", 32'(rinc), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    tick();
    rrst_n = 1'b1;
    k = done_cnt;
    repeat (3) tick();
    check("t5_no_done", 32'(done_cnt - k), 32'd0);
    check("t5_fifo_kept", 32'(fifo_q.size()), 32'd4);
    repeat (2) void'(ref_q.pop_front());
    do_burst(4);

    // Randomized bursts with random fill and random back-pressure
    for (int n = 0; n < 25; n++) begin
      len = int'($urandom_range(0, 31));
      pre = int'($urandom_range(0, 8));
      for (int i = 0; i < pre; i++) push_word(DSIZE'($urandom));
      ready_pct = int'($urandom_range(30, 100));
      wr_pct = 40;
      do_burst(len);
    end
    wr_pct = 0;
    ready_pct = 100;
    tick();

`ifdef FIFO_RD_CTRL_CNT_EN
    // Pop counter: reset, accumulate, saturate
    rrst_n = 1'b0;
    #1;
    check("cnt_reset", 32'(rd_count), 32'd0);
    clear_fifo();
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DSIZE'(i));
    do_burst(4);
    do_burst(3);
    check("cnt_seven", 32'(rd_count), 32'd7);
    dut.pop_count = 16'hFFFF;
    do_burst(1);
    check("cnt_saturate", 32'(rd_count), 32'h0000FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
